// File: rtl/mycountdowntimer_if.sv
// Command and display bundle between the countdown timer and its controller.
// Latency/backpressure are properties of the attached timer; this only groups wires.
interface mycountdowntimer_if;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] timerdisplay_min;
    logic [7:0] timerdisplay_sec;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output load, load_min, load_sec, start, pause,
        input  timerdisplay_min, timerdisplay_sec, running, done, expired
    );

    modport slave (
        input  load, load_min, load_sec, start, pause,
        output timerdisplay_min, timerdisplay_sec, running, done, expired
    );
endinterface

// File: rtl/mycountdowntimer.sv
// BCD mm:ss countdown timer, one decrement per TICKS_PER_SEC cycles; commands take effect 1 cycle
// after the sampling edge, all outputs registered; no backpressure, commands are single-cycle pulses.
module mycountdowntimer #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                myreset_n,
    mycountdowntimer_if.slave   tmr
);
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_min;
    logic [7:0]    r_sec;
    logic          r_running;
    logic          r_done;
    logic          r_expired;

    state_t        w_next_state;
    logic [PW-1:0] w_next_presc;
    logic [7:0]    w_next_min;
    logic [7:0]    w_next_sec;
    logic          w_next_expired;

    logic [7:0]    w_ld_min;
    logic [7:0]    w_ld_sec;
    logic [7:0]    w_dec_min;
    logic [7:0]    w_dec_sec;
    logic          w_is_zero;
    logic          w_dec_zero;
    logic          w_last_tick;

    // Out-of-range BCD digits saturate rather than wrap, so a bad load never shows garbage.
    always_comb begin
        w_ld_min[7:4] = (tmr.load_min[7:4] > 4'd9) ? 4'd9 : tmr.load_min[7:4];
        w_ld_min[3:0] = (tmr.load_min[3:0] > 4'd9) ? 4'd9 : tmr.load_min[3:0];
        w_ld_sec[7:4] = (tmr.load_sec[7:4] > 4'd5) ? 4'd5 : tmr.load_sec[7:4];
        w_ld_sec[3:0] = (tmr.load_sec[3:0] > 4'd9) ? 4'd9 : tmr.load_sec[3:0];
    end

    assign w_is_zero   = (r_min == 8'h00) && (r_sec == 8'h00);
    assign w_last_tick = (r_presc == LAST_TICK);

    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec;
        if (!w_is_zero) begin
            if (r_sec[3:0] != 4'd0) begin
                w_dec_sec[3:0] = r_sec[3:0] - 4'd1;
            end else begin
                w_dec_sec[3:0] = 4'd9;
                if (r_sec[7:4] != 4'd0) begin
                    w_dec_sec[7:4] = r_sec[7:4] - 4'd1;
                end else begin
                    w_dec_sec[7:4] = 4'd5;
                    if (r_min[3:0] != 4'd0) begin
                        w_dec_min[3:0] = r_min[3:0] - 4'd1;
                    end else begin
                        w_dec_min[3:0] = 4'd9;
                        w_dec_min[7:4] = r_min[7:4] - 4'd1;
                    end
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_min == 8'h00) && (w_dec_sec == 8'h00);

    always_comb begin
        w_next_state   = r_state;
        w_next_presc   = r_presc;
        w_next_min     = r_min;
        w_next_sec     = r_sec;
        w_next_expired = 1'b0;

        if (tmr.load) begin
            w_next_state = S_IDLE;
            w_next_presc = '0;
            w_next_min   = w_ld_min;
            w_next_sec   = w_ld_sec;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tmr.start && !w_is_zero) begin
                        w_next_state = S_RUN;
                        w_next_presc = '0;
                    end
                end
                S_RUN: begin
                    // A pause on the last tick freezes the prescaler there, so the
                    // decrement lands on the first cycle after resuming.
                    if (tmr.pause) begin
                        w_next_state = S_PAUSED;
                    end else if (w_last_tick) begin
                        w_next_presc = '0;
                        w_next_min   = w_dec_min;
                        w_next_sec   = w_dec_sec;
                        if (w_dec_zero) begin
                            w_next_state   = S_DONE;
                            w_next_expired = 1'b1;
                        end
                    end else begin
                        w_next_presc = r_presc + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (tmr.start && !tmr.pause) begin
                        w_next_state = S_RUN;
                    end
                end
                S_DONE: begin
                    w_next_state = S_DONE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge myreset_n) begin
        if (!myreset_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_presc   <= w_next_presc;
            r_min     <= w_next_min;
            r_sec     <= w_next_sec;
            r_running <= (w_next_state == S_RUN);
            r_done    <= (w_next_state == S_DONE);
            r_expired <= w_next_expired;
        end
    end

    assign tmr.timerdisplay_min = r_min;
    assign tmr.timerdisplay_sec = r_sec;
    assign tmr.running          = r_running;
    assign tmr.done             = r_done;
    assign tmr.expired          = r_expired;

endmodule

// File: tb/tb_mycountdowntimer.sv
// Directed bench for mycountdowntimer with a total-seconds reference model checked every cycle.
module tb_mycountdowntimer;
    localparam int T = 4;

    logic CLOCK_50 = 1'b0;
    logic myreset_n;

    always #5 CLOCK_50 = ~CLOCK_50;

    mycountdowntimer_if bus ();

    mycountdowntimer #(.TICKS_PER_SEC(T)) dut (
        .CLOCK_50  (CLOCK_50),
        .myreset_n (myreset_n),
        .tmr       (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    // Reference model: time kept as whole seconds, mode as plain flags.
    int m_secs  = 0;
    int m_phase = 0;
    bit m_run = 0, m_paused = 0, m_done = 0, m_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] b;
        b[7:4] = 4'((n / 10) % 10);
        b[3:0] = 4'(n % 10);
        return b;
    endfunction

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    always @(posedge CLOCK_50 or negedge myreset_n) begin
        if (!myreset_n) begin
            m_secs = 0; m_phase = 0;
            m_run = 0; m_paused = 0; m_done = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (bus.load) begin
                m_secs = (clampd(int'(bus.load_min[7:4]), 9) * 10 + clampd(int'(bus.load_min[3:0]), 9)) * 60
                       +  clampd(int'(bus.load_sec[7:4]), 5) * 10 + clampd(int'(bus.load_sec[3:0]), 9);
                m_phase = 0; m_run = 0; m_paused = 0; m_done = 0;
            end else if (m_run) begin
                if (bus.pause) begin
                    m_run = 0; m_paused = 1;
                end else if (m_phase == T - 1) begin
                    m_phase = 0;
                    m_secs  = m_secs - 1;
                    if (m_secs == 0) begin
                        m_run = 0; m_done = 1; m_exp = 1;
                    end
                end else begin
                    m_phase++;
                end
            end else if (m_paused) begin
                if (bus.start && !bus.pause) begin
                    m_paused = 0; m_run = 1;
                end
            end else if (!m_done) begin
                if (bus.start && m_secs > 0) begin
                    m_run = 1; m_phase = 0;
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        chk("disp_min", 32'(bus.timerdisplay_min), 32'(to_bcd(m_secs / 60)));
        chk("disp_sec", 32'(bus.timerdisplay_sec), 32'(to_bcd(m_secs % 60)));
        chk("running",  32'(bus.running), 32'(m_run));
        chk("done",     32'(bus.done),    32'(m_done));
        chk("expired",  32'(bus.expired), 32'(m_exp));
        if (bus.expired === 1'b1) exp_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] mn, input logic [7:0] sc);
        bus.load_min = mn; bus.load_sec = sc; bus.load = 1'b1;
        cyc(1);
        bus.load = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
    endtask

    task automatic chk_disp(input string name, input logic [7:0] mn, input logic [7:0] sc);
        chk({name, "_min"}, 32'(bus.timerdisplay_min), 32'(mn));
        chk({name, "_sec"}, 32'(bus.timerdisplay_sec), 32'(sc));
    endtask

    initial begin
        bus.load = 0; bus.start = 0; bus.pause = 0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;
        myreset_n = 1'b1;
        #1 myreset_n = 1'b0;
        #2;
        chk_disp("rst", 8'h00, 8'h00);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_expired", 32'(bus.expired), 0);
        cyc(2);
        myreset_n = 1'b1;
        cyc(1);

        // Basic count with borrow across the minute boundary.
        pulse_load(8'h01, 8'h00);
        pulse_start();
        cyc(3);
        chk_disp("pre_first", 8'h01, 8'h00);
        cyc(1);
        chk_disp("first_dec", 8'h00, 8'h59);
        chk("first_running", 32'(bus.running), 1);
        cyc(4);
        chk_disp("second_dec", 8'h00, 8'h58);

        pulse_load(8'h10, 8'h00);
        pulse_start();
        cyc(4);
        chk_disp("ten_borrow", 8'h09, 8'h59);

        // Expiry and DONE stickiness.
        pulse_load(8'h00, 8'h02);
        exp_count = 0;
        pulse_start();
        cyc(4);
        chk_disp("exp_1", 8'h00, 8'h01);
        cyc(3);
        chk("exp_done_early", 32'(bus.done), 0);
        cyc(1);
        chk_disp("exp_0", 8'h00, 8'h00);
        chk("exp_done", 32'(bus.done), 1);
        chk("exp_pulse", 32'(bus.expired), 1);
        cyc(1);
        chk("exp_pulse_end", 32'(bus.expired), 0);
        pulse_start();
        pulse_pause();
        pulse_start();
        cyc(10);
        chk("exp_once", 32'(exp_count), 1);
        chk("done_sticky", 32'(bus.done), 1);

        // Pause after two full RUN cycles, then resume.
        pulse_load(8'h00, 8'h05);
        pulse_start();
        cyc(2);
        pulse_pause();
        chk("paused_running", 32'(bus.running), 0);
        cyc(20);
        chk_disp("paused_hold", 8'h00, 8'h05);
        pulse_start();
        chk("resume_running", 32'(bus.running), 1);
        cyc(1);
        chk_disp("resume_1", 8'h00, 8'h05);
        cyc(1);
        chk_disp("resume_dec", 8'h00, 8'h04);

        // Load and start together, with clamping.
        bus.load_min = 8'h3C; bus.load_sec = 8'h7A; bus.load = 1'b1; bus.start = 1'b1;
        cyc(1);
        bus.load = 1'b0; bus.start = 1'b0;
        chk_disp("clamp", 8'h39, 8'h59);
        chk("clamp_model", 32'(m_secs), 32'(39 * 60 + 59));
        chk("clamp_idle", 32'(bus.running), 0);
        cyc(6);
        chk_disp("clamp_hold", 8'h39, 8'h59);

        // Load on the exact decrement edge.
        pulse_load(8'h00, 8'h10);
        pulse_start();
        cyc(3);
        pulse_load(8'h00, 8'h30);
        chk_disp("load_on_dec", 8'h00, 8'h30);
        chk("load_on_dec_run", 32'(bus.running), 0);
        cyc(5);
        chk_disp("load_on_dec_hold", 8'h00, 8'h30);

        // Zero load never starts.
        exp_count = 0;
        pulse_load(8'h00, 8'h00);
        pulse_start();
        cyc(6);
        chk("zero_running", 32'(bus.running), 0);
        chk("zero_done", 32'(bus.done), 0);
        chk("zero_noexp", 32'(exp_count), 0);

        // Asynchronous reset mid-count.
        pulse_load(8'h05, 8'h30);
        pulse_start();
        cyc(6);
        chk_disp("pre_reset", 8'h05, 8'h29);
        #2 myreset_n = 1'b0;
        #1;
        chk_disp("async_rst", 8'h00, 8'h00);
        chk("async_rst_running", 32'(bus.running), 0);
        chk("async_rst_done", 32'(bus.done), 0);
        chk("async_rst_expired", 32'(bus.expired), 0);
        cyc(2);
        myreset_n = 1'b1;
        cyc(1);
        pulse_start();
        cyc(6);
        chk("post_rst_running", 32'(bus.running), 0);
        chk_disp("post_rst", 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mycountdowntimer.md
# mycountdowntimer

BCD minutes:seconds countdown timer: the down-counting counterpart of the seconds display timer. It is loaded with a BCD mm:ss value, decrements once per second from CLOCK_50, and flags expiry at 00:00. It drives the seven-segment display path with the same packed BCD format used elsewhere: tens digit in [7:4], units in [3:0]. It sits beside the display timer in the synthesizer's timing/display section.

## Interface
- TICKS_PER_SEC, default 50000000: CLOCK_50 cycles per one-second decrement. Minimum 2.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- myreset_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle pulse that loads load_min/load_sec.
- load_min  in  8  BCD minutes to load, 00–99.
- load_sec  in  8  BCD seconds to load, 00–59.
- start  in  1  pulse that starts or resumes counting.
- pause  in  1  pulse that freezes counting.
- timerdisplay_min  out  8  current BCD minutes.
- timerdisplay_sec  out  8  current BCD seconds.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- expired  out  1  one-cycle pulse on reaching 00:00.

## Operation
- **States:** IDLE, RUN, PAUSED, DONE.
- **Reset (myreset_n low, asynchronous):**
  - state IDLE, display 00:00, prescaler 0.
  - running, done and expired all 0.
- **Command priority per cycle:** load > pause > start.
- **load (any state):**
  - Display takes the clamped load value.
  - Prescaler clears; state goes to IDLE.
  - Clamping: sec tens >5 becomes 5; any other digit >9 becomes 9.
- **IDLE:**
  - start with a nonzero display: go to RUN and clear the prescaler.
  - start with display 00:00: ignored.
  - pause: ignored.
- **RUN:**
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On the cycle the prescaler equals TICKS_PER_SEC-1, the display decrements by one second.
  - pause: go to PAUSED; prescaler holds its value.
  - start: ignored.
- **PAUSED:**
  - Display and prescaler hold.
  - start: go to RUN, resuming from the held prescaler value (no clear).
- **DONE:**
  - Display holds 00:00.
  - start and pause are ignored; only load or reset exits.
- **Decrement arithmetic (BCD, digit-wise borrow):**
  - sec units 0→9 with borrow, else -1.
  - sec tens 0→5 with borrow, else -1.
  - min units 0→9 with borrow, else -1.
  - min tens: decrement by 1 on borrow.
  - A value reaching 00:00 never decrements further, so no underflow or wrap.
- **Expiry:**
  - On the decrement edge that produces 00:00: state goes to DONE, done rises, and expired pulses for exactly that one cycle.
- **Simultaneous events:**
  - load on a decrement cycle: the load wins and no decrement occurs.
  - pause on a decrement cycle: the pause wins, the display does not change, and the prescaler holds at TICKS_PER_SEC-1. After resume, the decrement happens on the first RUN cycle.

## Timing
- All outputs are registered.
- load, start and pause are sampled on the rising edge; the state/display effect is visible after that edge (1-cycle latency).
- **First decrement** occurs TICKS_PER_SEC cycles after the edge that accepted start from IDLE.
- **Subsequent decrements** occur every TICKS_PER_SEC cycles while in RUN.
- **Pause/resume:** the cycles spent in RUN before and after a pause sum to TICKS_PER_SEC per decrement.
- **Output timing:**
  - running is high on exactly the cycles the state is RUN.
  - done is asserted in the same cycle as the display becomes 00:00.
  - expired is high for 1 cycle per expiry; it never re-fires while in DONE.
- **Reset mid-count:** outputs go to their reset values immediately (asynchronous). After release, the block sits in IDLE and requires a load and a start.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** assert myreset_n=0 mid-RUN at 05:30 → display 00:00 at once, running=0, done=0, expired=0. After release, start alone is ignored.
- **Basic count and borrows** (TICKS_PER_SEC=4): load 01:00, then start → display shows 00:59 exactly 4 cycles after the start edge, then 00:58 4 cycles later. Display is 10:00 → 09:59 on a later load of 10:00.
- **Expiry:** load 00:02, then start → 00:01, then 00:00 with done=1 and expired high for exactly 1 cycle. Further start pulses leave DONE unchanged and give no second expired pulse.
- **Pause/resume** (TICKS=4): load 00:05, start, pause after 2 RUN cycles, hold 20 cycles, start → next decrement after 2 more RUN cycles, to 00:04. running=0 throughout the pause.
- **Priority and clamping:**
  - load and start in the same cycle with load_min=8'h3C, load_sec=8'h7A → state IDLE, display 39:59.
  - load on a decrement cycle → loaded value shown, no decrement applied.
- **Zero load:** load 00:00, then start → stays IDLE, running=0, done=0, expired never pulses.
